// File: rtl/bk_spi_slave.sv
// bk_spi_slave: Motorola SPI responder configured through the SBKP write port;
// returns a preloaded byte on MISO and reports status/received data on bk_status.
module bk_spi_slave #(
  parameter int unsigned BKP_BASE_index = 810,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SCK_i,
  input  logic        SS_i,
  input  logic        MOSI_i,
  output logic        MISO_o,
  output logic        MISO_oe,
  input  logic        BkpCfg_Ready_i,
  input  logic [31:0] BkpCfg_DataIndex_i,
  input  logic [31:0] BkpCfg_DataValue_i,
  output logic [31:0] bk_status
);
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 8;
  localparam int unsigned CW = 3;
  localparam int unsigned MW = 3;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, ACTIVE = 2'd2} state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sck_prev_q, ss_prev_q;
  logic [1:0]             rdy_sync_q;
  logic                   rdy_prev_q;

  logic [MW-1:0] bk_mode_q;
  logic          desr_q, cpol_q, cpha_q, rec_clean_q;
  logic [BW-1:0] tx_buf_q;

  state_e        state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [BW-1:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d, rx_data_q, rx_data_d;
  logic          rec_vaild_q, rec_vaild_d, overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic          tx_empty_q, tx_empty_d, first_q, first_d, miso_q, miso_d, oe_q, oe_d;
  logic [DW-1:0] status_q, status_d;

  logic sck_s_c, ss_s_c, mosi_s_c, lead_c, trail_c, sample_c, shift_c;
  logic ss_fall_c, wr_c, tx_wr_c, busy_c, unused_bits_c;

  assign sck_s_c   = sck_sync_q[SYNC_STAGES-1];
  assign ss_s_c    = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s_c  = mosi_sync_q[SYNC_STAGES-1];
  assign lead_c    = cpol_q ? (sck_prev_q & ~sck_s_c) : (~sck_prev_q & sck_s_c);
  assign trail_c   = cpol_q ? (~sck_prev_q & sck_s_c) : (sck_prev_q & ~sck_s_c);
  assign sample_c  = cpha_q ? trail_c : lead_c;
  assign shift_c   = cpha_q ? lead_c : trail_c;
  assign ss_fall_c = ss_prev_q & ~ss_s_c;
  assign wr_c      = rdy_sync_q[1] & ~rdy_prev_q;
  assign tx_wr_c   = wr_c && (BkpCfg_DataIndex_i == DW'(BKP_BASE_index + 32'd2));
  assign busy_c    = (state_q != IDLE);
  assign unused_bits_c = ^{BkpCfg_DataValue_i[DW-1:BW], rx_shift_q[BW-1]};

  assign MISO_o    = miso_q;
  assign MISO_oe   = oe_q;
  assign bk_status = status_q;

  // Pin synchronizers and edge-detect history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      ss_prev_q   <= 1'b0;
      rdy_sync_q  <= '0;
      rdy_prev_q  <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], SCK_i};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI_i};
      sck_prev_q  <= sck_s_c;
      ss_prev_q   <= ss_s_c;
      rdy_sync_q  <= {rdy_sync_q[0], BkpCfg_Ready_i};
      rdy_prev_q  <= rdy_sync_q[1];
    end
  end

  // SBKP register file; rec_clean is a self-clearing pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bk_mode_q   <= '0;
      desr_q      <= 1'b0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      tx_buf_q    <= '0;
      rec_clean_q <= 1'b0;
    end else begin
      rec_clean_q <= 1'b0;
      if (wr_c) begin
        if (BkpCfg_DataIndex_i == '0) bk_mode_q <= BkpCfg_DataValue_i[MW-1:0];
        if (BkpCfg_DataIndex_i == DW'(BKP_BASE_index)) desr_q <= BkpCfg_DataValue_i[0];
        if (BkpCfg_DataIndex_i == DW'(BKP_BASE_index + 32'd1)) begin
          cpol_q <= BkpCfg_DataValue_i[1];
          cpha_q <= BkpCfg_DataValue_i[0];
        end
        if (tx_wr_c) tx_buf_q <= BkpCfg_DataValue_i[BW-1:0];
        if (BkpCfg_DataIndex_i == DW'(BKP_BASE_index + 32'd3)) rec_clean_q <= BkpCfg_DataValue_i[0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      rec_vaild_q <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      tx_empty_q  <= 1'b0;
      first_q     <= 1'b0;
      miso_q      <= 1'b1;
      oe_q        <= 1'b0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      rec_vaild_q <= rec_vaild_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      tx_empty_q  <= tx_empty_d;
      first_q     <= first_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      status_q    <= status_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    rec_vaild_d = rec_vaild_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    tx_empty_d  = tx_empty_q;
    first_d     = first_q;
    miso_d      = miso_q;
    if (rec_clean_q) begin
      rec_vaild_d = 1'b0;
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
    end
    if (!desr_q) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (ss_fall_c) state_d = LOAD;
        LOAD: begin
          state_d    = ACTIVE;
          tx_shift_d = tx_buf_q;
          tx_empty_d = 1'b1;
          bit_cnt_d  = '0;
          first_d    = 1'b1;
          miso_d     = tx_buf_q[BW-1];
        end
        ACTIVE: begin
          if (ss_s_c) begin
            state_d = IDLE;
            if (bit_cnt_q != '0) frame_err_d = 1'b1;
          end else if (sample_c) begin
            rx_shift_d = {rx_shift_q[BW-2:0], mosi_s_c};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            first_d    = 1'b0;
            if (bit_cnt_q == 3'd7) begin
              rx_data_d   = rx_shift_d;
              rec_vaild_d = 1'b1;
              if (rec_vaild_q && !rec_clean_q) overrun_d = 1'b1;
            end
          end else if (shift_c) begin
            // First shift edge of a CPHA=1 frame re-presents the bit driven in LOAD
            if (bit_cnt_q == '0 && first_q) begin
              miso_d = tx_shift_q[BW-1];
            end else if (bit_cnt_q == '0) begin
              tx_shift_d = tx_buf_q;
              tx_empty_d = 1'b1;
              miso_d     = tx_buf_q[BW-1];
            end else begin
              tx_shift_d = {tx_shift_q[BW-2:0], 1'b0};
              miso_d     = tx_shift_q[BW-2];
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (tx_wr_c) tx_empty_d = 1'b0;
    oe_d = desr_q && (state_d != IDLE);
  end

  always_comb begin
    status_d = status_q;
    case (bk_mode_q)
      3'd0:    status_d = {27'd0, frame_err_q, overrun_q, tx_empty_q, rec_vaild_q, busy_c};
      3'd1:    status_d = {24'd0, rx_data_q};
      3'd2:    status_d = '0;
      default: status_d = status_q;
    endcase
  end
endmodule

// File: tb/tb_bk_spi_slave.sv
// Scoreboard bench for bk_spi_slave: stimulus queues expectations, a negedge
// monitor assembles MISO bytes and checks queued status/pin expectations.
module tb_bk_spi_slave;
  localparam int unsigned BASE     = 810;
  localparam int unsigned K_STATUS = 0;
  localparam int unsigned K_OE     = 1;
  localparam int unsigned K_MISO   = 2;
  localparam int unsigned K_MQ     = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SCK_i = 1'b0;
  logic        SS_i = 1'b1;
  logic        MOSI_i = 1'b0;
  logic        BkpCfg_Ready_i = 1'b0;
  logic [31:0] BkpCfg_DataIndex_i = '0;
  logic [31:0] BkpCfg_DataValue_i = '0;
  logic        MISO_o, MISO_oe;
  logic [31:0] bk_status;

  typedef struct {
    int unsigned kind;
    logic [31:0] val;
    logic [95:0] tag;
  } exp_t;

  exp_t       sq[$];
  logic [7:0] mq[$];
  int         errors = 0;
  int         checks = 0;
  logic       tb_cpol = 1'b0;
  logic       tb_cpha = 1'b0;
  logic [7:0] m_byte = '0;
  int         m_cnt = 0;
  logic       m_sck = 1'b0;

  bk_spi_slave dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .SCK_i             (SCK_i),
    .SS_i              (SS_i),
    .MOSI_i            (MOSI_i),
    .MISO_o            (MISO_o),
    .MISO_oe           (MISO_oe),
    .BkpCfg_Ready_i    (BkpCfg_Ready_i),
    .BkpCfg_DataIndex_i(BkpCfg_DataIndex_i),
    .BkpCfg_DataValue_i(BkpCfg_DataValue_i),
    .bk_status         (bk_status)
  );

  always #5 clk = ~clk;

  // Monitor: master-side MISO capture plus queued output expectations
  always @(negedge clk) begin
    exp_t        it;
    logic [31:0] act;
    logic [7:0]  e;
    if (SS_i) begin
      m_cnt = 0;
    end else if ((SCK_i != m_sck) && MISO_oe && (((SCK_i != tb_cpol) ^ tb_cpha) == 1'b1)) begin
      m_byte = {m_byte[6:0], MISO_o};
      m_cnt++;
      if (m_cnt == 8) begin
        m_cnt = 0;
        checks++;
        if (mq.size() == 0) begin
          errors++;
          $display("FAIL miso_byte: got=%h with no byte expected", m_byte);
        end else begin
          e = mq.pop_front();
          if (m_byte !== e) begin
            errors++;
            $display("FAIL miso_byte: got=%h want=%h", m_byte, e);
          end
        end
      end
    end
    m_sck = SCK_i;
    while (sq.size() > 0) begin
      it = sq.pop_front();
      case (it.kind)
        K_STATUS: act = bk_status;
        K_OE:     act = {31'd0, MISO_oe};
        K_MISO:   act = {31'd0, MISO_o};
        K_MQ:     act = 32'(mq.size());
        default:  act = 'x;
      endcase
      checks++;
      if (act !== it.val) begin
        errors++;
        $display("FAIL %s: got=%h want=%h", it.tag, act, it.val);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int unsigned k, input logic [95:0] t, input logic [31:0] v);
    exp_t it;
    it.kind = k;
    it.tag  = t;
    it.val  = v;
    sq.push_back(it);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && sq.size() != 0; i++) tick(1);
  endtask

  task automatic cfg(input int unsigned idx, input logic [31:0] val);
    BkpCfg_DataIndex_i = idx;
    BkpCfg_DataValue_i = val;
    BkpCfg_Ready_i     = 1'b1;
    tick(4);
    BkpCfg_Ready_i     = 1'b0;
    tick(4);
  endtask

  task automatic frame_begin();
    SCK_i = tb_cpol;
    SS_i  = 1'b0;
    tick(8);
  endtask

  task automatic spi_byte(input logic [7:0] b, input int nbits);
    logic [7:0] sh;
    sh = b;
    for (int i = 0; i < nbits; i++) begin
      if (!tb_cpha) MOSI_i = sh[7];
      tick(8);
      SCK_i = ~SCK_i;
      if (tb_cpha) MOSI_i = sh[7];
      tick(8);
      SCK_i = ~SCK_i;
      sh = {sh[6:0], 1'b0};
    end
  endtask

  task automatic frame_end();
    tick(8);
    SS_i = 1'b1;
    tick(8);
  endtask

  initial begin
    tick(4);
    rst_n = 1'b1;
    tick(4);
    push_exp(K_STATUS, "rst_status", 32'h0);
    push_exp(K_OE, "rst_oe", 32'h0);
    push_exp(K_MISO, "rst_miso", 32'h1);
    drain();

    // Mode 0 single byte
    cfg(BASE, 32'h1);
    cfg(BASE + 1, 32'h0);
    cfg(BASE + 2, 32'h3C);
    push_exp(K_STATUS, "t1_idle", 32'h0);
    drain();
    mq.push_back(8'h3C);
    frame_begin();
    push_exp(K_STATUS, "t1_busy", 32'h5);
    push_exp(K_OE, "t1_oe_on", 32'h1);
    drain();
    spi_byte(8'hA5, 8);
    tick(8);
    push_exp(K_STATUS, "t1_done", 32'h7);
    drain();
    SS_i = 1'b1;
    tick(8);
    push_exp(K_STATUS, "t1_idle_end", 32'h6);
    push_exp(K_OE, "t1_oe_off", 32'h0);
    drain();
    cfg(0, 32'h1);
    push_exp(K_STATUS, "t1_rxdata", 32'hA5);
    drain();
    cfg(0, 32'h0);

    // Mode 3, two-byte frame without tx_buf rewrite
    tb_cpol = 1'b1;
    tb_cpha = 1'b1;
    SCK_i   = 1'b1;
    cfg(BASE + 1, 32'h3);
    cfg(BASE + 2, 32'h81);
    mq.push_back(8'h81);
    mq.push_back(8'h81);
    frame_begin();
    spi_byte(8'h12, 8);
    spi_byte(8'h34, 8);
    frame_end();
    push_exp(K_STATUS, "t2_status", 32'hE);
    push_exp(K_MQ, "t2_miso_left", 32'h0);
    drain();

    // rec_clean then read rx_data
    cfg(BASE + 3, 32'h1);
    push_exp(K_STATUS, "t3_clean", 32'h4);
    drain();
    cfg(0, 32'h1);
    push_exp(K_STATUS, "t3_rxdata", 32'h34);
    drain();
    cfg(0, 32'h0);

    // Partial frame: SS raised after 5 bits
    frame_begin();
    spi_byte(8'hFF, 5);
    frame_end();
    push_exp(K_STATUS, "t4_frame_err", 32'h14);
    drain();
    cfg(0, 32'h1);
    push_exp(K_STATUS, "t4_rx_keep", 32'h34);
    drain();
    cfg(0, 32'h0);
    cfg(BASE + 3, 32'h1);
    push_exp(K_STATUS, "t4_clean", 32'h4);
    drain();

    // Disabled block ignores a full frame
    cfg(BASE, 32'h0);
    frame_begin();
    push_exp(K_OE, "t5_oe_start", 32'h0);
    push_exp(K_STATUS, "t5_st_start", 32'h4);
    drain();
    spi_byte(8'h77, 8);
    push_exp(K_OE, "t5_oe_end", 32'h0);
    push_exp(K_STATUS, "t5_st_mid", 32'h4);
    drain();
    frame_end();
    push_exp(K_STATUS, "t5_st_end", 32'h4);
    push_exp(K_MQ, "t5_miso_left", 32'h0);
    drain();

    // Async reset during bit 3, then a clean frame
    tb_cpol = 1'b0;
    tb_cpha = 1'b0;
    SCK_i   = 1'b0;
    cfg(BASE, 32'h1);
    cfg(BASE + 1, 32'h0);
    cfg(BASE + 2, 32'hC3);
    frame_begin();
    spi_byte(8'h5A, 2);
    tick(4);
    rst_n = 1'b0;
    tick(2);
    push_exp(K_STATUS, "t6_rst_st", 32'h0);
    push_exp(K_OE, "t6_rst_oe", 32'h0);
    push_exp(K_MISO, "t6_rst_miso", 32'h1);
    drain();
    rst_n = 1'b1;
    tick(8);
    push_exp(K_OE, "t6_no_restart", 32'h0);
    push_exp(K_STATUS, "t6_idle_st", 32'h0);
    drain();
    SS_i = 1'b1;
    tick(8);
    cfg(BASE, 32'h1);
    cfg(BASE + 2, 32'h96);
    mq.push_back(8'h96);
    frame_begin();
    spi_byte(8'h5A, 8);
    frame_end();
    push_exp(K_STATUS, "t6_status", 32'h6);
    push_exp(K_MQ, "t6_miso_left", 32'h0);
    drain();
    cfg(0, 32'h1);
    push_exp(K_STATUS, "t6_rxdata", 32'h5A);
    drain();

    tick(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
